// File: rtl/boot_packer_pkg.sv
// Shared definitions for the boot loader packer: destination codes,
// per-destination word sizes and the FSM state type.
package common_params;

   localparam logic [2:0] DEST_IMEM = 3'b100;
   localparam logic [2:0] DEST_DMEM = 3'b010;
   localparam logic [2:0] DEST_IB   = 3'b001;

   localparam int IMEM_BPW_DEFAULT = 4;
   localparam int DMEM_BPW_DEFAULT = 4;
   localparam int IB_BPW_DEFAULT   = 384;

   typedef enum logic [2:0] {
      HDR,
      LEN_HI,
      LEN_LO,
      DATA,
      WRITE,
      DONE
   } state_t;

   // A header is usable only when exactly one destination bit is set.
   function automatic logic is_valid_dest(input logic [2:0] code);
      return (code == DEST_IMEM) || (code == DEST_DMEM) || (code == DEST_IB);
   endfunction

endpackage

// File: rtl/boot_packer_byte_shifter.sv
// Byte-lane accumulator: each load drops a byte into the next free lane,
// so bytes arrive little-endian; clear empties the word and the count.
module byte_shifter #(
   parameter int BYTES = 384,
   parameter int CNT_W = $clog2(BYTES + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               load,
   input  logic [7:0]         din,
   output logic [BYTES*8-1:0] data,
   output logic [CNT_W-1:0]   count
);

   // Clear wins over load so a new word never inherits a stale lane.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data  <= '0;
         count <= '0;
      end else if (clear) begin
         data  <= '0;
         count <= '0;
      end else if (load && (count < CNT_W'(BYTES))) begin
         data[{count, 3'b000} +: 8] <= din;
         count                      <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/boot_packer.sv
// Boot frame packer: parses header/length, packs payload bytes into
// destination-sized words and presents each word on a valid/ready port.
module boot_packer
   import common_params::*;
#(
   parameter int DATA_BYTES_MAX = 384,
   parameter int IMEM_BPW       = IMEM_BPW_DEFAULT,
   parameter int DMEM_BPW       = DMEM_BPW_DEFAULT,
   parameter int IB_BPW         = IB_BPW_DEFAULT,
   parameter int ADDR_W         = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  rx_data,
   input  logic                        rx_valid,
   output logic                        rx_ready,
   output logic [2:0]                  wr_dest,
   output logic [ADDR_W-1:0]           wr_addr,
   output logic [DATA_BYTES_MAX*8-1:0] wr_data,
   output logic                        wr_valid,
   input  logic                        wr_ready,
   output logic                        done,
   output logic                        err
);

   localparam int CNT_W = $clog2(DATA_BYTES_MAX + 1);

   if ((IMEM_BPW > DATA_BYTES_MAX) || (DMEM_BPW > DATA_BYTES_MAX) ||
       (IB_BPW > DATA_BYTES_MAX) || (IMEM_BPW < 1) || (DMEM_BPW < 1) ||
       (IB_BPW < 1)) begin : g_bpw_check
      $error("boot_packer: bytes-per-word must lie in 1..DATA_BYTES_MAX");
   end

   state_t            state;
   logic [2:0]        dest;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] len;
   logic [ADDR_W-1:0] len_in;
   logic [7:0]        len_hi;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  bpw_cur;
   logic              rx_fire;
   logic              last_byte;
   logic              last_word;
   logic              clear;
   logic              load;

   always_comb begin
      bpw_cur = CNT_W'(IB_BPW);
      if (dest == DEST_IMEM) begin
         bpw_cur = CNT_W'(IMEM_BPW);
      end else if (dest == DEST_DMEM) begin
         bpw_cur = CNT_W'(DMEM_BPW);
      end
   end

   assign rx_fire   = rx_valid && rx_ready;
   assign len_in    = ADDR_W'({len_hi, rx_data});
   assign last_byte = (count == bpw_cur - CNT_W'(1));
   assign last_word = (addr == len - ADDR_W'(1));
   assign load      = (state == DATA) && rx_fire;
   // The word is emptied when a frame's payload begins and after every
   // consumed word that is not the final one.
   assign clear     = ((state == LEN_LO) && rx_fire) ||
                      ((state == WRITE) && wr_ready && !last_word);

   assign wr_dest = dest;
   assign wr_addr = addr;

   byte_shifter #(
      .BYTES (DATA_BYTES_MAX),
      .CNT_W (CNT_W)
   ) u_shifter (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .load  (load),
      .din   (rx_data),
      .data  (wr_data),
      .count (count)
   );

   // Handshake outputs are registered alongside the state so each one
   // changes exactly on the transition that defines it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= HDR;
         dest     <= '0;
         addr     <= '0;
         len      <= '0;
         len_hi   <= '0;
         rx_ready <= 1'b1;
         wr_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            HDR: begin
               if (rx_fire) begin
                  if (is_valid_dest(rx_data[2:0])) begin
                     dest  <= rx_data[2:0];
                     state <= LEN_HI;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            LEN_HI: begin
               if (rx_fire) begin
                  len_hi <= rx_data;
                  state  <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (rx_fire) begin
                  len  <= len_in;
                  addr <= '0;
                  if (len_in == '0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     rx_ready <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (rx_fire && last_byte) begin
                  state    <= WRITE;
                  wr_valid <= 1'b1;
                  rx_ready <= 1'b0;
               end
            end
            WRITE: begin
               if (wr_ready) begin
                  wr_valid <= 1'b0;
                  if (last_word) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     addr     <= addr + ADDR_W'(1);
                     state    <= DATA;
                     rx_ready <= 1'b1;
                  end
               end
            end
            DONE: begin
               state    <= HDR;
               rx_ready <= 1'b1;
            end
            default: begin
               state    <= HDR;
               rx_ready <= 1'b1;
               wr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/boot_packer.md
BOOT_PACKER -- requirements
Module: boot_packer

Interface
REQ-001 SHALL have parameter DATA_BYTES_MAX, default 384, giving the widest word in bytes and the wr_data width (DATA_BYTES_MAX*8).
REQ-002 SHALL have parameter IMEM_BPW, default 4, giving bytes per I_MEM word.
REQ-003 SHALL have parameter DMEM_BPW, default 4, giving bytes per D_MEM word.
REQ-004 SHALL have parameter IB_BPW, default 384, giving bytes per IMAGE_BUFFER word.
REQ-005 SHALL have parameter ADDR_W, default 16, giving the word address and length-field width.
REQ-006 SHALL use one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 rx_data  input  8  received byte.
REQ-010 rx_valid  input  1  rx_data valid.
REQ-011 rx_ready  output  1  byte accepted when rx_valid&&rx_ready.
REQ-012 wr_dest  output  3  one-hot destination (100 I_MEM, 010 D_MEM, 001 IMAGE_BUFFER).
REQ-013 wr_addr  output  ADDR_W  word address.
REQ-014 wr_data  output  DATA_BYTES_MAX*8  assembled word, zero-padded above the active bytes.
REQ-015 wr_valid  output  1  word presented.
REQ-016 wr_ready  input  1  word consumed when wr_valid&&wr_ready.
REQ-017 done  output  1  one-cycle pulse at frame end.
REQ-018 err  output  1  one-cycle pulse on a bad header.

Function
REQ-019 Frame format SHALL be: header byte, then length high byte, then length low byte (word count N), then N*BPW(dest) payload bytes.
REQ-020 FSM states SHALL be HDR, LEN_HI, LEN_LO, DATA, WRITE, DONE.
REQ-021 In HDR, the low 3 bits of the accepted byte SHALL be checked: exactly one bit set latches the destination and moves to LEN_HI; any other value pulses err the next cycle and stays in HDR.
REQ-022 The upper 5 header bits SHALL be ignored.
REQ-023 LEN_HI then LEN_LO SHALL latch N; if N==0 the FSM goes to DONE, otherwise to DATA with the byte count and wr_addr cleared.
REQ-024 Payload SHALL be little-endian: byte k of the word goes to wr_data[8k+7:8k].
REQ-025 After BPW(dest) bytes the FSM SHALL enter WRITE with wr_valid=1, holding wr_data, wr_addr and wr_dest stable until the handshake completes.
REQ-026 In WRITE, rx_ready SHALL be 0.
REQ-027 In all other states except DONE, rx_ready SHALL be 1.
REQ-028 On a WRITE handshake: if it was word N-1 the FSM goes to DONE; otherwise wr_addr increments by 1, the byte count and wr_data clear, and the FSM returns to DATA.
REQ-029 DONE SHALL assert done for exactly 1 cycle, then return to HDR.
REQ-030 When wr_ready is held high, the WRITE-to-DATA transition SHALL cost exactly 1 cycle per word (one bubble).
REQ-031 wr_addr SHALL wrap modulo 2^ADDR_W without error.
REQ-032 Bytes offered while rx_ready=0 SHALL be neither consumed nor lost.
REQ-033 A BPW greater than DATA_BYTES_MAX SHALL be rejected by an elaboration-time assertion.

Reset
REQ-034 While rst_n=0 at a clk edge, the block SHALL enter HDR with rx_ready=1, wr_valid=0, done=0, err=0, wr_addr=0, wr_data=0 and wr_dest=000.
REQ-035 A reset mid-frame (including in WRITE) SHALL abandon the frame, drop any pending word, and emit no done pulse.

Structure
REQ-036 Destination encodings (I_MEM, D_MEM, IMAGE_BUFFER), the per-destination bytes-per-word defaults and the FSM state enum SHALL live in the shared common_params package.
REQ-037 A sub-module byte_shifter (a byte-lane accumulator with clear, load-at-index and count) SHALL hold wr_data and the byte count.

Verification
REQ-038 Header 0x04, length 0x0002, bytes 11 22 33 44 55 66 77 88, wr_ready=1 -> two writes: addr 0 data 0x44332211 and addr 1 data 0x88776655, both with wr_dest=100, followed by one done pulse.
REQ-039 Header 0x01, length 1, 384 bytes 0..383 mod 256 -> one write to dest 001, addr 0, with byte k = k mod 256.
REQ-040 Header 0x06 -> err pulse, no write; a following valid D_MEM frame (0x02, length 1, AA BB CC DD) completes normally with data 0xDDCCBBAA.
REQ-041 wr_ready held low for 10 cycles in WRITE -> wr_valid, data and addr stable and rx_ready=0 throughout; the offered byte is consumed after the handshake.
REQ-042 Header 0x02, length 0 -> done 1 cycle after LEN_LO, no write.
REQ-043 rst_n pulsed low after 2 payload bytes -> outputs at reset values, no done pulse; a new frame starting at addr 0 passes.
